// File: rtl/alu_multicycle_scheduler.sv
// Multi-cycle execute sequencer for the EX stage: issues work to the pipelined
// multiplier or the FP adder, stalls the pipeline while the unit is busy, and
// presents the captured result for exactly one cycle.
module alu_multicycle_scheduler #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned FPU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [5:0]  ALU_operation,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        mul_start,
    output logic [1:0]  mul_func,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    output logic        fpu_start,
    output logic        fpu_sub,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_result,
    output logic        ex_stall,
    output logic        mc_result_valid,
    output logic [31:0] mc_result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, FPU_WAIT, DONE} state_t;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] FPU_LAT_C = 4'(FPU_LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mul_start_q, mul_start_d;
    logic [1:0]  mul_func_q, mul_func_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        fpu_start_q, fpu_start_d;
    logic        fpu_sub_q, fpu_sub_d;
    logic [31:0] fpu_a_q, fpu_a_d;
    logic [31:0] fpu_b_q, fpu_b_d;
    logic [31:0] mc_result_q, mc_result_d;
    logic        mc_result_valid_q, mc_result_valid_d;

    logic is_mul, is_fp, issue_mul, issue_fp;

    // Decode the op class; 6'b11_1111 and everything else outside these is single-cycle.
    always_comb begin
        is_mul    = (ALU_operation[5:4] == 2'b01);
        is_fp     = (ALU_operation[5:1] == 5'b11000);
        issue_mul = ex_valid & is_mul & ~flush;
        issue_fp  = ex_valid & is_fp & ~flush;
    end

    // Next-state logic: issue from IDLE, count down the unit latency, capture, then one DONE cycle.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        mul_start_d       = 1'b0;
        mul_func_d        = mul_func_q;
        mul_a_d           = mul_a_q;
        mul_b_d           = mul_b_q;
        fpu_start_d       = 1'b0;
        fpu_sub_d         = fpu_sub_q;
        fpu_a_d           = fpu_a_q;
        fpu_b_d           = fpu_b_q;
        mc_result_d       = mc_result_q;
        mc_result_valid_d = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_mul) begin
                        mul_a_d     = rs1_data;
                        mul_b_d     = rs2_data;
                        mul_func_d  = ALU_operation[1:0];
                        mul_start_d = 1'b1;
                        cnt_d       = MUL_LAT_C;
                        state_d     = MUL_WAIT;
                    end else if (issue_fp) begin
                        fpu_a_d     = rs1_data;
                        fpu_b_d     = rs2_data;
                        fpu_sub_d   = ALU_operation[0];
                        fpu_start_d = 1'b1;
                        cnt_d       = FPU_LAT_C;
                        state_d     = FPU_WAIT;
                    end
                end
                MUL_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        mc_result_d       = mul_result;
                        mc_result_valid_d = 1'b1;
                        state_d           = DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                FPU_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        mc_result_d       = fpu_result;
                        mc_result_valid_d = 1'b1;
                        state_d           = DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the issuing instruction is held in the very cycle it is decoded.
    always_comb begin
        ex_stall = 1'b0;
        case (state_q)
            IDLE:     ex_stall = ex_valid & (is_mul | is_fp) & ~flush;
            MUL_WAIT: ex_stall = 1'b1;
            FPU_WAIT: ex_stall = 1'b1;
            default:  ex_stall = 1'b0;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= 4'd0;
            mul_start_q       <= 1'b0;
            mul_func_q        <= 2'd0;
            mul_a_q           <= 32'd0;
            mul_b_q           <= 32'd0;
            fpu_start_q       <= 1'b0;
            fpu_sub_q         <= 1'b0;
            fpu_a_q           <= 32'd0;
            fpu_b_q           <= 32'd0;
            mc_result_q       <= 32'd0;
            mc_result_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            mul_start_q       <= mul_start_d;
            mul_func_q        <= mul_func_d;
            mul_a_q           <= mul_a_d;
            mul_b_q           <= mul_b_d;
            fpu_start_q       <= fpu_start_d;
            fpu_sub_q         <= fpu_sub_d;
            fpu_a_q           <= fpu_a_d;
            fpu_b_q           <= fpu_b_d;
            mc_result_q       <= mc_result_d;
            mc_result_valid_q <= mc_result_valid_d;
        end
    end

    assign mul_start       = mul_start_q;
    assign mul_func        = mul_func_q;
    assign mul_a           = mul_a_q;
    assign mul_b           = mul_b_q;
    assign fpu_start       = fpu_start_q;
    assign fpu_sub         = fpu_sub_q;
    assign fpu_a           = fpu_a_q;
    assign fpu_b           = fpu_b_q;
    assign mc_result       = mc_result_q;
    assign mc_result_valid = mc_result_valid_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_multicycle_scheduler.sv
// Self-checking bench for alu_multicycle_scheduler with behavioural multiplier
// and FP-adder models and a result scoreboard.
module tb_alu_multicycle_scheduler;

    localparam int MUL_LAT = 3;
    localparam int FPU_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [5:0]  ALU_operation;
    logic [31:0] rs1_data, rs2_data;
    logic        flush;
    logic        mul_start, fpu_start, fpu_sub, ex_stall, mc_result_valid, busy;
    logic [1:0]  mul_func;
    logic [31:0] mul_a, mul_b, mul_result, fpu_a, fpu_b, fpu_result, mc_result;

    int vectors = 0;
    int miscompares = 0;
    int valid_pulses = 0;
    int mul_starts = 0;
    int fpu_starts = 0;
    logic [31:0] sb [$];

    alu_multicycle_scheduler #(.MUL_LAT(MUL_LAT), .FPU_LAT(FPU_LAT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ALU_operation(ALU_operation),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .mul_start(mul_start), .mul_func(mul_func), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .fpu_start(fpu_start), .fpu_sub(fpu_sub),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result), .ex_stall(ex_stall),
        .mc_result_valid(mc_result_valid), .mc_result(mc_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference multiplier arithmetic, RISC-V M semantics.
    function automatic logic [31:0] mulModel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        logic [63:0] p;
        case (f)
            2'b00:   p = {32'b0, a} * {32'b0, b};
            2'b01:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b10:   p = {{32{a[31]}}, a} * {32'b0, b};
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Tiny FP adder model covering the operand pairs this bench uses.
    function automatic logic [31:0] fpuModel(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (a == 32'h40400000 && b == 32'h3F800000 && s) return 32'h40000000;
        if (a == 32'h3FC00000 && b == 32'h40200000 && !s) return 32'h40800000;
        return 32'h0;
    endfunction

    // Fixed-latency unit models: result appears LAT cycles after the start cycle.
    logic [31:0] mul_pipe [MUL_LAT];
    logic [31:0] fpu_pipe [FPU_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= 32'h0;
            for (int i = 0; i < FPU_LAT; i++) fpu_pipe[i] <= 32'h0;
        end else begin
            mul_pipe[0] <= mul_start ? mulModel(mul_a, mul_b, mul_func) : 32'h0;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
            fpu_pipe[0] <= fpu_start ? fpuModel(fpu_a, fpu_b, fpu_sub) : 32'h0;
            for (int i = 1; i < FPU_LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
        end
    end
    assign mul_result = mul_pipe[MUL_LAT-1];
    assign fpu_result = fpu_pipe[FPU_LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Scoreboard and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (mul_start === 1'b1) mul_starts++;
            if (fpu_start === 1'b1) fpu_starts++;
            if (mc_result_valid === 1'b1) begin
                valid_pulses++;
                if (sb.size() == 0) checkOutput("unexpected_valid", 32'd1, 32'd0);
                else checkOutput("mc_result", mc_result, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multi-cycle op in the current (IDLE) cycle and walk it cycle by cycle to DONE.
    // Returns in the IDLE cycle after DONE with the op still on the inputs.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit is_mul, input int lat, input logic [31:0] exp_res,
                                 input bit drop_valid);
        ex_valid = 1'b1; ALU_operation = op; rs1_data = a; rs2_data = b; flush = 1'b0;
        #1;
        checkOutput("t0_stall", ex_stall, 1);
        checkOutput("t0_busy", busy, 0);
        sb.push_back(exp_res);
        step();
        checkOutput("t1_mul_start", mul_start, is_mul);
        checkOutput("t1_fpu_start", fpu_start, !is_mul);
        if (is_mul) begin
            checkOutput("t1_mul_a", mul_a, a);
            checkOutput("t1_mul_b", mul_b, b);
            checkOutput("t1_mul_func", mul_func, op[1:0]);
        end else begin
            checkOutput("t1_fpu_a", fpu_a, a);
            checkOutput("t1_fpu_b", fpu_b, b);
            checkOutput("t1_fpu_sub", fpu_sub, op[0]);
        end
        checkOutput("t1_stall", ex_stall, 1);
        checkOutput("t1_busy", busy, 1);
        if (drop_valid) ex_valid = 1'b0;
        for (int k = 2; k <= lat + 1; k++) begin
            step();
            checkOutput("wait_starts", {mul_start, fpu_start}, 0);
            checkOutput("wait_stall", ex_stall, 1);
            checkOutput("wait_valid", mc_result_valid, 0);
        end
        step();
        checkOutput("done_valid", mc_result_valid, 1);
        checkOutput("done_stall", ex_stall, 0);
        checkOutput("done_busy", busy, 1);
        step();
        checkOutput("post_valid", mc_result_valid, 0);
        checkOutput("post_starts", {mul_start, fpu_start}, 0);
        checkOutput("post_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ALU_operation = 6'h0; rs1_data = 0; rs2_data = 0; flush = 1'b0;
        step(); step();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", mc_result_valid, 0);
        checkOutput("rst_result", mc_result, 0);
        checkOutput("rst_mul_a", mul_a, 0);
        checkOutput("rst_starts", {mul_start, fpu_start}, 0);
        rst = 1'b0;

        // Single-cycle ops, including the 11_1111 corner, never stall or start.
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1'b1; ALU_operation = (i == 2) ? 6'b11_1111 : 6'b00_0010;
            rs1_data = 32'd5; rs2_data = 32'd9;
            #1;
            checkOutput("add_stall", ex_stall, 0);
            step();
            checkOutput("add_starts", {mul_start, fpu_start}, 0);
            checkOutput("add_busy", busy, 0);
        end

        // Flush in IDLE suppresses issue.
        ex_valid = 1'b1; ALU_operation = 6'b01_0000; flush = 1'b1;
        #1;
        checkOutput("idle_flush_stall", ex_stall, 0);
        step();
        checkOutput("idle_flush_busy", busy, 0);
        checkOutput("idle_flush_start", mul_start, 0);
        flush = 1'b0;

        applyStimulus(6'b01_0000, 32'd7, 32'd6, 1'b1, MUL_LAT, 32'd42, 1'b0);
        applyStimulus(6'b11_0001, 32'h40400000, 32'h3F800000, 1'b0, FPU_LAT, 32'h40000000, 1'b0);
        applyStimulus(6'b01_0011, 32'hFFFFFFFF, 32'h2, 1'b1, MUL_LAT, 32'h1, 1'b1);
        applyStimulus(6'b11_0000, 32'h3FC00000, 32'h40200000, 1'b0, FPU_LAT, 32'h40800000, 1'b0);

        // Flush at T2 of a MUL: back to IDLE at T3 with no result.
        ex_valid = 1'b1; ALU_operation = 6'b01_0000; rs1_data = 32'd3; rs2_data = 32'd4;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0; ALU_operation = 6'b00_0010;
        #1;
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_stall", ex_stall, 0);
        checkOutput("flush_valid", mc_result_valid, 0);
        checkOutput("flush_keep_result", mc_result, 32'h40800000);
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            step();
            checkOutput("flush_add_stall", ex_stall, 0);
            checkOutput("flush_no_valid", mc_result_valid, 0);
        end

        // Reset at T2 of an FADD: everything back to reset values at T3.
        ex_valid = 1'b1; ALU_operation = 6'b11_0000; rs1_data = 32'h3FC00000; rs2_data = 32'h40200000;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; ex_valid = 1'b0;
        #1;
        checkOutput("mrst_busy", busy, 0);
        checkOutput("mrst_stall", ex_stall, 0);
        checkOutput("mrst_starts", {mul_start, fpu_start}, 0);
        checkOutput("mrst_fpu_sub", fpu_sub, 0);
        checkOutput("mrst_fpu_a", fpu_a, 0);
        checkOutput("mrst_fpu_b", fpu_b, 0);
        checkOutput("mrst_mul_func", mul_func, 0);
        checkOutput("mrst_result", mc_result, 0);
        checkOutput("mrst_valid", mc_result_valid, 0);
        step();

        applyStimulus(6'b01_0000, 32'd1000, 32'hFFFFFFFD, 1'b1, MUL_LAT, 32'hFFFFF448, 1'b0);
        ex_valid = 1'b0;
        step(); step();

        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("valid_pulses", valid_pulses, 5);
        checkOutput("mul_start_pulses", mul_starts, 4);
        checkOutput("fpu_start_pulses", fpu_starts, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
